// File: rtl/shift_sequencer_if.sv
// Request/result bundle between an issuing unit (master) and shift_sequencer (slave).
// The sh_rot wire exists only when SHIFT_SEQ_ROT_EN is defined.
interface shift_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
);
    logic              start;
    logic              sh_dir;
    logic [AMT_W-1:0]  sh_amt;
    logic [DATA_W-1:0] d_in;
`ifdef SHIFT_SEQ_ROT_EN
    logic              sh_rot;
`endif
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] d_out;

`ifdef SHIFT_SEQ_ROT_EN
    modport master (output start, sh_dir, sh_amt, d_in, sh_rot,
                    input  busy, done, d_out);
    modport slave  (input  start, sh_dir, sh_amt, d_in, sh_rot,
                    output busy, done, d_out);
`else
    modport master (output start, sh_dir, sh_amt, d_in,
                    input  busy, done, d_out);
    modport slave  (input  start, sh_dir, sh_amt, d_in,
                    output busy, done, d_out);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one shift stage per clock, amount bits applied MSB-first
// (2^(AMT_W-1) ... 1), so a full op always takes AMT_W stage cycles plus one FIN cycle.
// Optional rotate mode is built only when SHIFT_SEQ_ROT_EN is defined.
module shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus
);
    // Stage index only needs to count AMT_W-1 down to 0.
    localparam int K_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] work;
    logic [AMT_W-1:0]  amt_q;
    logic              dir_q;
`ifdef SHIFT_SEQ_ROT_EN
    logic              rot_q;
`endif
    logic [K_W-1:0]    k;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] d_out_q;

    logic [DATA_W-1:0] stage_out;
    logic              accept;

    // A request is taken only in IDLE or in the FIN cycle; START during SHIFT is dropped.
    assign accept = bus.start && (state == IDLE || state == FIN);

    // One shift/rotate stage of width 2^k applied to the working register.
    always_comb begin
        int unsigned sh;
        sh        = 1 << k;
        stage_out = work;
        if (amt_q[k]) begin
`ifdef SHIFT_SEQ_ROT_EN
            if (rot_q) begin
                if (dir_q) stage_out = (work >> sh) | (work << (DATA_W - sh));
                else       stage_out = (work << sh) | (work >> (DATA_W - sh));
            end else
`endif
            if (dir_q) stage_out = $signed(work) >>> sh;
            else       stage_out = work << sh;
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            amt_q   <= '0;
            dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_ROT_EN
            rot_q   <= 1'b0;
`endif
            k       <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_out_q <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        work   <= bus.d_in;
                        amt_q  <= bus.sh_amt;
                        dir_q  <= bus.sh_dir;
`ifdef SHIFT_SEQ_ROT_EN
                        rot_q  <= bus.sh_rot;
`endif
                        k      <= K_W'(AMT_W - 1);
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    if (k == '0) begin
                        // Last stage: publish the result in the same edge.
                        d_out_q <= stage_out;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= FIN;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d_out = d_out_q;

    // Handshake outputs are mutually exclusive by construction.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer with a behavioural shift model.
// Rotate cases run only when SHIFT_SEQ_ROT_EN is defined.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.DATA_W(32), .AMT_W(5)) bus ();

    shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the whole shift as one arithmetic expression.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dir,
                                              input logic [4:0] amt, input logic rot);
        logic [31:0] r;
        if (rot) r = dir ? ((d >> amt) | (d << (32 - amt))) : ((d << amt) | (d >> (32 - amt)));
        else     r = dir ? 32'($signed(d) >>> amt) : (d << amt);
        return r;
    endfunction

    task automatic drive(input logic [31:0] d, input logic dir, input logic [4:0] amt, input logic rot);
        bus.d_in   = d;
        bus.sh_dir = dir;
        bus.sh_amt = amt;
`ifdef SHIFT_SEQ_ROT_EN
        bus.sh_rot = rot;
`else
        if (rot) bus.sh_dir = dir;
`endif
    endtask

    task automatic scramble();
        drive($urandom, 1'($urandom), 5'($urandom), 1'($urandom));
    endtask

    // Single op with START pulsed for one cycle; checks latency, busy, result and hold.
    task automatic single_op(input string tag, input logic [31:0] d, input logic dir,
                             input logic [4:0] amt, input logic rot);
        logic [31:0] exp;
        int cnt;
        exp = ref_shift(d, dir, amt, rot);
        @(negedge clk);
        drive(d, dir, amt, rot);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        cnt = 0;
        while (!bus.done && cnt < 20) begin
            chk({tag, " busy"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
            cnt++;
            scramble();
        end
        chk({tag, " latency"}, cnt, 32'd5);
        chk({tag, " result"}, bus.d_out, exp);
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " hold"}, bus.d_out, exp);
    endtask

    // Back-to-back ops with START held high; each result must arrive 6 cycles apart.
    task automatic b2b(input string tag, input int n, input logic [31:0] d0);
        logic [31:0] d[8];
        logic        dir[8];
        logic [4:0]  amt[8];
        logic        rot[8];
        int cnt;
        for (int i = 0; i < n; i++) begin
            d[i] = $urandom; dir[i] = 1'($urandom); amt[i] = 5'($urandom);
`ifdef SHIFT_SEQ_ROT_EN
            rot[i] = 1'($urandom);
`else
            rot[i] = 1'b0;
`endif
        end
        d[0] = d0; dir[0] = 1'b0; amt[0] = 5'd0; rot[0] = 1'b0;
        @(negedge clk);
        drive(d[0], dir[0], amt[0], rot[0]);
        bus.start = 1'b1;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (!bus.done) scramble();
            end while (!bus.done && cnt < 20);
            chk($sformatf("%s op%0d spacing", tag, i), cnt, 32'd6);
            chk($sformatf("%s op%0d result", tag, i), bus.d_out, ref_shift(d[i], dir[i], amt[i], rot[i]));
            if (i < n - 1) drive(d[i+1], dir[i+1], amt[i+1], rot[i+1]);
            else           bus.start = 1'b0;
        end
        @(negedge clk);
        chk({tag, " end_done_low"}, 32'(bus.done), 32'd0);
    endtask

    // BUSY and DONE must never be seen together.
    always @(negedge clk) begin
        if (!rst) chk("busy_done_excl", 32'(bus.busy && bus.done), 32'd0);
    end

    initial begin
        int pulses;
        logic [31:0] seen;
        bus.start = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst d_out", bus.d_out, 32'd0);
        rst = 1'b0;

        // Directed cases
        single_op("asr4", 32'h8000_0000, 1'b1, 5'd4, 1'b0);
        chk("asr4 value", bus.d_out, 32'hF800_0000);
        single_op("lsl17", 32'h0000_FFFF, 1'b0, 5'd17, 1'b0);
        chk("lsl17 value", bus.d_out, 32'hFFFE_0000);
        single_op("asr31_pos", 32'h7FFF_FFFF, 1'b1, 5'd31, 1'b0);
        chk("asr31_pos value", bus.d_out, 32'h0);
        single_op("asr31_neg", 32'h8000_0001, 1'b1, 5'd31, 1'b0);
        chk("asr31_neg value", bus.d_out, 32'hFFFF_FFFF);
        single_op("amt0", 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        chk("amt0 value", bus.d_out, 32'hDEAD_BEEF);
        b2b("b2b", 5, 32'hDEAD_BEEF);

        // START during SHIFT is ignored
        @(negedge clk);
        drive(32'h1, 1'b0, 5'd8, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(32'hFFFF_FFFF, 1'b1, 5'd3, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        seen   = '0;
        repeat (12) begin
            if (bus.done) begin pulses++; seen = bus.d_out; end
            @(negedge clk);
        end
        chk("ignore pulses", pulses, 32'd1);
        chk("ignore result", seen, 32'h0000_0100);

        // Reset mid-operation aborts without a DONE
        @(negedge clk);
        drive(32'h1234_5678, 1'b0, 5'd3, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort d_out", bus.d_out, 32'd0);
        pulses = 0;
        repeat (10) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        chk("abort no_done", pulses, 32'd0);
        single_op("post_abort", 32'hCAFE_F00D, 1'b1, 5'd12, 1'b0);

`ifdef SHIFT_SEQ_ROT_EN
        single_op("ror1", 32'h0000_0001, 1'b1, 5'd1, 1'b1);
        chk("ror1 value", bus.d_out, 32'h8000_0000);
        single_op("rol4", 32'hF000_0000, 1'b0, 5'd4, 1'b1);
        chk("rol4 value", bus.d_out, 32'h0000_000F);
`endif

        // Random single ops
        for (int i = 0; i < 30; i++) begin
            logic r;
`ifdef SHIFT_SEQ_ROT_EN
            r = 1'($urandom);
`else
            r = 1'b0;
`endif
            single_op($sformatf("rnd%0d", i), $urandom, 1'($urandom), 5'($urandom), r);
        end
        b2b("b2b_rnd", 6, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
